mem_bus_fabric: RTL and testbench
=================================

Name: mem_bus_fabric

Overview:
- Parametrised interconnect between the picorv32 native memory interface (valid/ready) and NUM_SLAVES memory-mapped slaves.
- Replaces the hard-wired address compare and read-data mux in the system top with a registered, table-driven decoder.
- Adds per-slave wait-state support, bus timeout, an error response for unmapped addresses, and error reporting.
- Sits directly between the core and the RAM, UART and GPIO slaves.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- SLV_BASE, {32'h1000_0010, 32'h1000_0000, 32'h0000_1000, 32'h0000_0000}, packed NUM_SLAVES x 32 base addresses; slave 0 is the LSB slice.
- SLV_MASK, {32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_F000, 32'hFFFF_F000}, packed address masks; hit = (addr & MASK) == BASE.
- TIMEOUT, 255, maximum wait cycles in ACCESS before an error response (1..65535).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- m_valid_i  in  1  core request valid.
- m_instr_i  in  1  instruction fetch flag (forwarded only).
- m_addr_i  in  32  core address.
- m_wdata_i  in  DATA_W  core write data.
- m_wstrb_i  in  DATA_W/8  byte strobes; all zero means read.
- m_ready_o  out  1  one-cycle completion pulse to the core.
- m_rdata_o  out  DATA_W  registered read data, valid while m_ready_o=1.
- s_valid_o  out  NUM_SLAVES  one-hot slave request.
- s_addr_o  out  32  latched address, shared by all slaves.
- s_wdata_o  out  DATA_W  latched write data, shared.
- s_wstrb_o  out  DATA_W/8  latched strobes, shared.
- s_ready_i  in  NUM_SLAVES  per-slave completion.
- s_rdata_i  in  NUM_SLAVES*DATA_W  packed per-slave read data.
- err_o  out  1  one-cycle pulse on decode miss or timeout.
- err_addr_o  out  32  address of the most recent error, held.
- err_count_o  out  8  saturating error count.

Behaviour:
- Reset: state IDLE. All outputs are 0, except m_rdata_o=0 and err_addr_o=0. Timeout counter is cleared. Reset mid-transaction aborts it without issuing a ready pulse.
- IDLE, when m_valid_i=1:
  - Latch addr, wdata and wstrb.
  - Decode using the lowest-index hit; overlapping windows resolve to the lower index.
  - Hit: go to ACCESS and set s_valid_o to one-hot(sel) on the next cycle.
  - Miss: go to RESP with rdata=ERR_DATA and err_o=1 on the RESP cycle.
- ACCESS:
  - s_valid_o[sel] stays high. The counter increments every cycle.
  - If s_ready_i[sel]=1: capture s_rdata_i[sel] (captured for writes too) and go to RESP.
  - Else if counter == TIMEOUT-1: go to RESP with ERR_DATA and flag an error.
  - s_ready_i on non-selected slaves is ignored.
- RESP:
  - m_ready_o=1 for exactly one cycle. s_valid_o=0.
  - On error: err_o=1, err_addr_o=latched address, err_count_o increments and saturates at 255.
  - Return to IDLE.
- Latency:
  - Request seen at cycle t, slave ready at t+1 gives m_ready_o at t+2 (minimum 2 cycles).
  - A slave asserting ready k cycles after s_valid gives m_ready_o at t+2+k.
  - A decode miss gives m_ready_o at t+1.
- Back-to-back: IDLE accepts a new m_valid_i in the cycle after RESP. No request is accepted while not in IDLE.
- m_valid_i dropping mid-transaction is illegal for the core. The fabric completes the transaction anyway and issues m_ready_o.
- Simultaneous ready and timeout on the same cycle: ready wins, no error.
- m_instr_i is not used for decode.

Decomposition:
- Package mem_bus_fabric_pkg holds:
  - state encoding (IDLE, ACCESS, RESP);
  - the default ERR_DATA constant;
  - the default memory map constants (RAM, GPIO, UART bases/masks).
- Sub-module fabric_addr_decode: combinational priority decoder. Inputs are address, SLV_BASE and SLV_MASK; outputs are a hit flag and a binary index.
- FSM, latches, timeout counter and error registers live in mem_bus_fabric.

Test Plan:
1. Read 0x0000_0040, slave 0 ready one cycle after s_valid with rdata 0x1234_5678 -> s_valid_o=4'b0001 at t+1, m_ready_o at t+2, m_rdata_o=0x1234_5678, err_o never asserted.
2. Write 0x1000_0000, wdata 0xA5, wstrb 4'b0001, slave 2 inserts 3 wait states -> s_wstrb_o=4'b0001, s_wdata_o=0xA5, m_ready_o at t+5, err_count_o=0.
3. Read 0x2000_0000 (unmapped) -> no s_valid_o bit set, m_ready_o at t+1, m_rdata_o=0xDEAD_BEEF, err_o pulse, err_addr_o=0x2000_0000, err_count_o=1.
4. TIMEOUT=8, slave 3 (0x1000_0014) never ready -> s_valid_o[3] high for exactly 8 cycles, then m_ready_o with 0xDEAD_BEEF, err_o=1.
5. rst_i asserted during a slave-1 ACCESS wait -> next cycle s_valid_o=0, m_ready_o stays 0, state IDLE; a new read afterwards completes normally.
6. 300 back-to-back misses -> err_count_o saturates at 255. Overlapping-window map with address in both slaves 0 and 1 -> only s_valid_o[0] is asserted.

Source files
------------

// File: rtl/mem_bus_fabric_pkg.sv
// Shared types and default memory map for the core-to-slave memory fabric.
package mem_bus_fabric_pkg;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} fab_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [31:0] RAM0_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM0_MASK = 32'hFFFF_F000;
  localparam logic [31:0] RAM1_BASE = 32'h0000_1000;
  localparam logic [31:0] RAM1_MASK = 32'hFFFF_F000;
  localparam logic [31:0] UART_BASE = 32'h1000_0000;
  localparam logic [31:0] UART_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] GPIO_BASE = 32'h1000_0010;
  localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFF0;

  // Slave 0 occupies the least significant slice.
  localparam logic [127:0] DEFAULT_SLV_BASE = {GPIO_BASE, UART_BASE, RAM1_BASE, RAM0_BASE};
  localparam logic [127:0] DEFAULT_SLV_MASK = {GPIO_MASK, UART_MASK, RAM1_MASK, RAM0_MASK};

endpackage

// File: rtl/fabric_addr_decode.sv
// Combinational priority address decoder; overlapping windows resolve to the lowest index.
module fabric_addr_decode #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic [31:0]              addr_i,
  input  logic [NUM_SLAVES*32-1:0] base_i,
  input  logic [NUM_SLAVES*32-1:0] mask_i,
  output logic                     hit_o,
  output logic [SEL_W-1:0]         idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    // Scan high to low so the last match written is the lowest index.
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((addr_i & mask_i[i*32 +: 32]) == base_i[i*32 +: 32]) begin
        hit_o = 1'b1;
        idx_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// Registered valid/ready fabric between the core and NUM_SLAVES slaves, with
// wait states, timeout, decode-miss error response and error reporting.
module mem_bus_fabric
  import mem_bus_fabric_pkg::*;
#(
  parameter int unsigned               NUM_SLAVES = 4,
  parameter int unsigned               DATA_W     = 32,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE   = DEFAULT_SLV_BASE,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK   = DEFAULT_SLV_MASK,
  parameter int unsigned               TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]         ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m_valid_i,
  input  logic                         m_instr_i,
  input  logic [31:0]                  m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  input  logic [DATA_W/8-1:0]          m_wstrb_i,
  output logic                         m_ready_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic [NUM_SLAVES-1:0]        s_valid_o,
  output logic [31:0]                  s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [DATA_W/8-1:0]          s_wstrb_o,
  input  logic [NUM_SLAVES-1:0]        s_ready_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
  output logic                         err_o,
  output logic [31:0]                  err_addr_o,
  output logic [7:0]                   err_count_o
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  fab_state_e        state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [15:0]       cnt_q;
  logic              dec_hit;
  logic [SEL_W-1:0]  dec_idx;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              timeout_hit;
  logic              unused_instr;

  // Instruction-fetch flag plays no part in routing.
  assign unused_instr = m_instr_i;

  fabric_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_decode (
    .addr_i (m_addr_i),
    .base_i (SLV_BASE),
    .mask_i (SLV_MASK),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign sel_ready   = s_ready_i[sel_q];
  assign sel_rdata   = s_rdata_i[sel_q*DATA_W +: DATA_W];
  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cnt_q       <= '0;
      m_ready_o   <= 1'b0;
      m_rdata_o   <= '0;
      s_valid_o   <= '0;
      s_addr_o    <= '0;
      s_wdata_o   <= '0;
      s_wstrb_o   <= '0;
      err_o       <= 1'b0;
      err_addr_o  <= '0;
      err_count_o <= '0;
    end else begin
      m_ready_o <= 1'b0;
      err_o     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (m_valid_i) begin
            s_addr_o  <= m_addr_i;
            s_wdata_o <= m_wdata_i;
            s_wstrb_o <= m_wstrb_i;
            if (dec_hit) begin
              sel_q     <= dec_idx;
              s_valid_o <= NUM_SLAVES'(1) << dec_idx;
              state_q   <= StAccess;
            end else begin
              m_rdata_o  <= ERR_DATA;
              m_ready_o  <= 1'b1;
              err_o      <= 1'b1;
              err_addr_o <= m_addr_i;
              if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
              state_q    <= StResp;
            end
          end
        end
        StAccess: begin
          cnt_q <= cnt_q + 16'd1;
          // Ready takes precedence over a timeout on the same cycle.
          if (sel_ready) begin
            m_rdata_o <= sel_rdata;
            s_valid_o <= '0;
            m_ready_o <= 1'b1;
            state_q   <= StResp;
          end else if (timeout_hit) begin
            m_rdata_o  <= ERR_DATA;
            s_valid_o  <= '0;
            m_ready_o  <= 1'b1;
            err_o      <= 1'b1;
            err_addr_o <= s_addr_o;
            if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
            state_q    <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric: reads, waited writes, misses, timeout,
// mid-transaction reset, error-count saturation and overlapping windows.
module tb_mem_bus_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_valid, m_instr;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  // Second instance with overlapping windows for slaves 0 and 1.
  logic         o_valid;
  logic [31:0]  o_addr;
  logic         o_ready;
  logic [31:0]  o_rdata;
  logic [3:0]   o_s_valid;
  logic [31:0]  o_s_addr, o_s_wdata;
  logic [3:0]   o_s_wstrb;
  logic         o_err;
  logic [31:0]  o_err_addr;
  logic [7:0]   o_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_fabric #(
    .TIMEOUT (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_valid_i   (m_valid),
    .m_instr_i   (m_instr),
    .m_addr_i    (m_addr),
    .m_wdata_i   (m_wdata),
    .m_wstrb_i   (m_wstrb),
    .m_ready_o   (m_ready),
    .m_rdata_o   (m_rdata),
    .s_valid_o   (s_valid),
    .s_addr_o    (s_addr),
    .s_wdata_o   (s_wdata),
    .s_wstrb_o   (s_wstrb),
    .s_ready_i   (s_ready),
    .s_rdata_i   (s_rdata),
    .err_o       (err),
    .err_addr_o  (err_addr),
    .err_count_o (err_count)
  );

  mem_bus_fabric #(
    .SLV_BASE ({32'h1000_0010, 32'h1000_0000, 32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK ({32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_F000, 32'hFFFF_0000}),
    .TIMEOUT  (8)
  ) dut_ovl (
    .clk_i       (clk),
    .rst_i       (rst),
    .m_valid_i   (o_valid),
    .m_instr_i   (1'b0),
    .m_addr_i    (o_addr),
    .m_wdata_i   (32'h0),
    .m_wstrb_i   (4'h0),
    .m_ready_o   (o_ready),
    .m_rdata_o   (o_rdata),
    .s_valid_o   (o_s_valid),
    .s_addr_o    (o_s_addr),
    .s_wdata_o   (o_s_wdata),
    .s_wstrb_o   (o_s_wstrb),
    .s_ready_i   (o_s_valid),
    .s_rdata_i   (128'h0),
    .err_o       (o_err),
    .err_addr_o  (o_err_addr),
    .err_count_o (o_err_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int high_cycles;
    rst = 1'b1; m_valid = 1'b0; m_instr = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; s_rdata = '0; o_valid = 1'b0; o_addr = '0;
    step(); step();
    check_eq("rst_m_ready", 32'(m_ready), 32'd0);
    check_eq("rst_s_valid", 32'(s_valid), 32'd0);
    check_eq("rst_rdata", m_rdata, 32'h0);
    check_eq("rst_err_addr", err_addr, 32'h0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    step();

    // 1: read slave 0, ready one cycle after s_valid.
    m_valid = 1'b1; m_addr = 32'h0000_0040; m_wstrb = 4'h0; m_instr = 1'b1;
    step();
    check_eq("t1_s_valid", 32'(s_valid), 32'h1);
    check_eq("t1_m_ready_t1", 32'(m_ready), 32'd0);
    check_eq("t1_err_t1", 32'(err), 32'd0);
    m_valid = 1'b0; m_instr = 1'b0;
    s_ready = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
    step();
    check_eq("t1_m_ready_t2", 32'(m_ready), 32'd1);
    check_eq("t1_rdata", m_rdata, 32'h1234_5678);
    check_eq("t1_err_t2", 32'(err), 32'd0);
    check_eq("t1_s_valid_resp", 32'(s_valid), 32'h0);
    s_ready = '0;
    step();
    check_eq("t1_ready_pulse", 32'(m_ready), 32'd0);

    // 2: write slave 2 with three wait states.
    m_valid = 1'b1; m_addr = 32'h1000_0000; m_wdata = 32'h0000_00A5; m_wstrb = 4'b0001;
    step();
    check_eq("t2_s_valid", 32'(s_valid), 32'h4);
    check_eq("t2_s_wstrb", 32'(s_wstrb), 32'h1);
    check_eq("t2_s_wdata", s_wdata, 32'h0000_00A5);
    check_eq("t2_s_addr", s_addr, 32'h1000_0000);
    m_valid = 1'b0; m_wstrb = '0; m_wdata = '0;
    step();
    check_eq("t2_wait_t2", 32'(m_ready), 32'd0);
    step();
    check_eq("t2_wait_t3", 32'(m_ready), 32'd0);
    step();
    check_eq("t2_wait_t4", 32'(m_ready), 32'd0);
    s_ready = 4'b0100; s_rdata[95:64] = 32'h0000_0077;
    step();
    check_eq("t2_m_ready_t5", 32'(m_ready), 32'd1);
    check_eq("t2_err_count", 32'(err_count), 32'd0);
    s_ready = '0;
    step();

    // 3: unmapped read.
    m_valid = 1'b1; m_addr = 32'h2000_0000;
    step();
    check_eq("t3_s_valid", 32'(s_valid), 32'h0);
    check_eq("t3_m_ready", 32'(m_ready), 32'd1);
    check_eq("t3_rdata", m_rdata, 32'hDEAD_BEEF);
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_err_addr", err_addr, 32'h2000_0000);
    check_eq("t3_err_count", 32'(err_count), 32'd1);
    m_valid = 1'b0;
    step();
    check_eq("t3_err_pulse", 32'(err), 32'd0);

    // 4: slave 3 never ready, TIMEOUT=8.
    m_valid = 1'b1; m_addr = 32'h1000_0014;
    step();
    check_eq("t4_s_valid", 32'(s_valid), 32'h8);
    m_valid = 1'b0;
    high_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_valid[3]) high_cycles++;
      else break;
    end
    check_eq("t4_valid_cycles", 32'(high_cycles), 32'd8);
    check_eq("t4_m_ready", 32'(m_ready), 32'd1);
    check_eq("t4_rdata", m_rdata, 32'hDEAD_BEEF);
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_err_addr", err_addr, 32'h1000_0014);
    check_eq("t4_err_count", 32'(err_count), 32'd2);
    step();

    // 5: reset during a slave 1 wait.
    m_valid = 1'b1; m_addr = 32'h0000_1004;
    step();
    check_eq("t5_s_valid", 32'(s_valid), 32'h2);
    m_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_eq("t5_s_valid_rst", 32'(s_valid), 32'h0);
    check_eq("t5_m_ready_rst", 32'(m_ready), 32'd0);
    rst = 1'b0;
    step();
    check_eq("t5_m_ready_after", 32'(m_ready), 32'd0);
    m_valid = 1'b1; m_addr = 32'h0000_0080;
    step();
    check_eq("t5_new_s_valid", 32'(s_valid), 32'h1);
    m_valid = 1'b0; s_ready = 4'b0001; s_rdata[31:0] = 32'hCAFE_0001;
    step();
    check_eq("t5_new_m_ready", 32'(m_ready), 32'd1);
    check_eq("t5_new_rdata", m_rdata, 32'hCAFE_0001);
    s_ready = '0;
    step();

    // 6a: 300 back-to-back misses saturate the error count.
    m_valid = 1'b1; m_addr = 32'h3000_0000;
    pulses = 0;
    for (int i = 0; i < 700 && pulses < 300; i++) begin
      step();
      if (m_ready) pulses++;
      if (pulses == 300) m_valid = 1'b0;
    end
    m_valid = 1'b0;
    check_eq("t6_pulses", 32'(pulses), 32'd300);
    step();
    check_eq("t6_err_count_sat", 32'(err_count), 32'd255);
    check_eq("t6_err_addr", err_addr, 32'h3000_0000);

    // 6b: overlapping windows pick the lower index.
    o_valid = 1'b1; o_addr = 32'h0000_0100;
    step();
    check_eq("t6_ovl_s_valid", 32'(o_s_valid), 32'h1);
    o_valid = 1'b0;
    step();
    check_eq("t6_ovl_m_ready", 32'(o_ready), 32'd1);
    check_eq("t6_ovl_err", 32'(o_err), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
